// File: rtl/minhash_sequencer.sv
// Sequences one MinHash comparison: clear, stream NUM_HASH pairs, drain DP_LAT, capture; start-to-done 2+NUM_HASH+DP_LAT cycles.
// No backpressure. Defining MINHASH_SEQ_RUNCNT_EN adds the 16-bit runCount output.
module minhash_sequencer #(
   parameter int NUM_HASH = 8,
   parameter int COEF_W   = 32,
   parameter int SIM_W    = 5,
   parameter int DP_LAT   = 2,
   localparam int IDX_W   = (NUM_HASH > 1) ? $clog2(NUM_HASH) : 1
) (
   input  logic              clk,
   input  logic              rstN,
   input  logic              start,
   input  logic              abort,
   input  logic              cfgWe,
   input  logic [IDX_W-1:0]  cfgAddr,
   input  logic [COEF_W-1:0] cfgA,
   input  logic [COEF_W-1:0] cfgB,
   output logic              cfgErr,
   output logic              dpClear,
   output logic              dpValid,
   output logic [COEF_W-1:0] dpRandA,
   output logic [COEF_W-1:0] dpRandB,
   input  logic [SIM_W-1:0]  dpSimilarity,
   output logic              busy,
   output logic              done,
   output logic [SIM_W-1:0]  similarity
`ifdef MINHASH_SEQ_RUNCNT_EN
   ,
   output logic [15:0]       runCount
`endif
);

   typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_FEED, S_DRAIN, S_DONE} state_e;

   localparam int               LAT_W    = (DP_LAT > 1) ? $clog2(DP_LAT) : 1;
   localparam int               LAT_LAST = (DP_LAT > 0) ? DP_LAT - 1 : 0;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_HASH - 1);

   state_e            state_q, state_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [LAT_W-1:0]  lat_q, lat_d;

   logic [COEF_W-1:0] tab_a [NUM_HASH];
   logic [COEF_W-1:0] tab_b [NUM_HASH];

   logic              clear_q, clear_d;
   logic              valid_q, valid_d;
   logic [COEF_W-1:0] rand_a_q, rand_a_d;
   logic [COEF_W-1:0] rand_b_q, rand_b_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic [SIM_W-1:0]  sim_q;
   logic              cfg_err_q;
   logic              cfg_addr_ok, cfg_accept;

   assign cfg_addr_ok = ({1'b0, cfgAddr} < (IDX_W + 1)'(NUM_HASH));
   assign cfg_accept  = cfgWe && !busy_q && cfg_addr_ok;

   always_comb begin
      state_d = state_q;
      idx_d   = '0;
      lat_d   = '0;
      case (state_q)
         S_IDLE:  if (start) state_d = S_CLEAR;
         S_CLEAR: state_d = abort ? S_IDLE : S_FEED;
         S_FEED: begin
            if (abort) begin
               state_d = S_IDLE;
            end else if (idx_q == IDX_LAST) begin
               state_d = (DP_LAT == 0) ? S_DONE : S_DRAIN;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         S_DRAIN: begin
            if (abort) begin
               state_d = S_IDLE;
            end else if (lat_q == LAT_W'(LAT_LAST)) begin
               state_d = S_DONE;
            end else begin
               lat_d = lat_q + 1'b1;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs are decoded from the next state so every port comes straight from a flop.
   always_comb begin
      clear_d  = (state_d == S_CLEAR);
      valid_d  = (state_d == S_FEED);
      busy_d   = (state_d != S_IDLE);
      done_d   = (state_d == S_DONE);
      rand_a_d = valid_d ? tab_a[idx_d] : '0;
      rand_b_d = valid_d ? tab_b[idx_d] : '0;
   end

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         state_q   <= S_IDLE;
         idx_q     <= '0;
         lat_q     <= '0;
         clear_q   <= 1'b0;
         valid_q   <= 1'b0;
         rand_a_q  <= '0;
         rand_b_q  <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         sim_q     <= '0;
         cfg_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         lat_q     <= lat_d;
         clear_q   <= clear_d;
         valid_q   <= valid_d;
         rand_a_q  <= rand_a_d;
         rand_b_q  <= rand_b_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         if (done_d) sim_q <= dpSimilarity;
         cfg_err_q <= cfgWe && !cfg_accept;
      end
   end

   // Coefficient table survives reset so a host need not reload it.
   always_ff @(posedge clk) begin
      if (cfg_accept) begin
         tab_a[cfgAddr] <= cfgA;
         tab_b[cfgAddr] <= cfgB;
      end
   end

`ifdef MINHASH_SEQ_RUNCNT_EN
   logic [15:0] run_cnt_q;

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         run_cnt_q <= '0;
      end else if (state_q == S_DONE) begin
         run_cnt_q <= run_cnt_q + 16'd1;
      end
   end

   assign runCount = run_cnt_q;
`endif

   assign cfgErr     = cfg_err_q;
   assign dpClear    = clear_q;
   assign dpValid    = valid_q;
   assign dpRandA    = rand_a_q;
   assign dpRandB    = rand_b_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign similarity = sim_q;

endmodule

// File: doc/minhash_sequencer.md
# minhash_sequencer

Controller that sequences the MinHash/Jaccard datapath (`topDesginModule`) for one comparison of two k-mer sets.
- On a start request it clears the datapath.
- It then streams `NUM_HASH` (randA, randB) hash-coefficient pairs from an internal programmable table, one per cycle.
- It waits the datapath's fixed drain latency, captures the similarity count and raises `done`.
- It sits between the host/config interface and the datapath, replacing hand-driven coefficient sequencing.

## Interface
- `NUM_HASH`, 8, number of coefficient pairs per run (table depth), ≥1
- `COEF_W`, 32, width of randA/randB
- `SIM_W`, 5, width of similarity result
- `DP_LAT`, 2, datapath cycles from last coefficient to valid result, ≥0
- `clk`  in  1  single clock, all logic on rising edge
- `rstN`  in  1  asynchronous, active-low reset
- `start`  in  1  run request, sampled in IDLE only
- `abort`  in  1  cancel current run
- `cfgWe`  in  1  table write strobe
- `cfgAddr`  in  $clog2(NUM_HASH)  table slot
- `cfgA`, `cfgB`  in  COEF_W  coefficient pair to write
- `cfgErr`  out  1  one-cycle pulse: write rejected
- `dpClear`  out  1  one-cycle datapath clear pulse
- `dpValid`  out  1  coefficient pair valid this cycle
- `dpRandA`, `dpRandB`  out  COEF_W  coefficients to datapath
- `dpSimilarity`  in  SIM_W  datapath result
- `busy`  out  1  high in any state except IDLE
- `done`  out  1  one-cycle pulse, result captured
- `similarity`  out  SIM_W  last captured result

## Operation
- FSM states: IDLE, CLEAR, FEED, DRAIN, DONE.
- IDLE, `start`=1: go to CLEAR. `start` in any other state is ignored; there is no queueing.
- CLEAR: `dpClear`=1 for one cycle. Go to FEED with `idx`=0.
- FEED: `dpValid`=1, `dpRandA`/`dpRandB` = table[`idx`].
  - `idx` increments each cycle.
  - After slot `NUM_HASH`-1: go to DRAIN, or to DONE when `DP_LAT`=0.
- DRAIN: counts `DP_LAT` cycles, then goes to DONE.
- DONE: `done`=1 for one cycle. Go to IDLE.
  - `similarity` is loaded from `dpSimilarity` on the edge entering DONE.
- `abort`=1 in CLEAR/FEED/DRAIN: go to IDLE on the next edge.
  - No `done`; `similarity` is unchanged.
  - `dpValid` drops immediately on that edge.
  - `abort` in IDLE or DONE has no effect. DONE completes normally.
- `abort` and `start` together in IDLE: start wins.
- Table writes:
  - Accepted only when `busy`=0.
  - A write while busy is dropped and `cfgErr` pulses the next cycle.
  - A write to `cfgAddr` ≥ `NUM_HASH` is dropped with `cfgErr`.
- The table is not cleared by reset. Its contents are undefined until written.
- `dpRandA`/`dpRandB` are 0 whenever `dpValid`=0.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `dpClear`=0, `dpValid`=0, `dpRandA`=`dpRandB`=0, `similarity`=0, `cfgErr`=0, `idx`=0.
- All outputs are registered.
- Edge E0 samples `start`. Cycle schedule:
  - Cycle after E0: `dpClear`.
  - Next `NUM_HASH` cycles: `dpValid`.
  - Then `DP_LAT` DRAIN cycles.
  - Then one `done` cycle.
- Start-to-done latency is 2+`NUM_HASH`+`DP_LAT` cycles after E0. With defaults, `done` is high in cycle 12.
- `busy` rises in the cycle after E0 and falls in the cycle after `done`.
- Earliest restart: `start` sampled on the edge ending the DONE cycle is ignored, because state is still DONE. The next run can be accepted on the following edge.
- Asynchronous `rstN` assertion mid-run forces reset values immediately, with no `done`. The table keeps its contents.

## Configuration
- `MINHASH_SEQ_RUNCNT_EN` defined adds output `runCount` (16 bits).
  - Reset value 0.
  - Increments on each DONE cycle and wraps 0xFFFF→0.
  - Aborted runs do not count.
- Undefined: port and counter are absent. Behaviour is otherwise identical.

## Test plan
- Basic run:
  - Stimulus: load slots 0–7 with (10323,10091), (2324,1), (358771,233), (409712,76423), (94390,4232409), (2229481,57554), (123,2231130), (1441,1091); datapath stub returns 5'd13; pulse `start`.
  - Response: `dpClear` in cycle 1; the 8 pairs in order in cycles 2–9; `done` in cycle 12; `similarity`=13.
- Abort:
  - Stimulus: `abort` during FEED slot 4.
  - Response: `dpValid` low next cycle; no `done`; `similarity` keeps its prior value; a new `start` runs all 8 slots.
- Config errors:
  - Stimulus: write while busy; separately, write with `cfgAddr`=8 when `NUM_HASH`=8 is not applicable (8 = power of two), so use `NUM_HASH`=6 and `cfgAddr`=7.
  - Response: both dropped; `cfgErr` pulses once each; table unchanged.
- Start while busy:
  - Stimulus: `start` held high through an entire run.
  - Response: exactly one run per IDLE visit; back-to-back `done` pulses 13 cycles apart.
- Reset mid-run:
  - Stimulus: `rstN` low during DRAIN.
  - Response: outputs at reset values immediately, no `done`; after release, a run uses the preserved table.
- `DP_LAT`=0 build, with `MINHASH_SEQ_RUNCNT_EN`:
  - Response: `done` in cycle 10; `runCount` steps 0→1→2 over two runs; starting from preset 0xFFFF it wraps to 0.
